// File: rtl/bit_serial_pkg.sv
// Shared widths, state type and length decoding for the bit serializer.
package bit_serial_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = $clog2(WORD_W + 1);

  typedef enum logic {IDLE, SHIFT} ser_state_e;

  // 0 selects a full word; anything above WORD_W is clamped to a full word.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] num_bits);
    logic [CNT_W-1:0] len;
    len = num_bits;
    if (num_bits == '0 || num_bits > CNT_W'(WORD_W)) len = CNT_W'(WORD_W);
    return len;
  endfunction

endpackage

// File: rtl/ser_pend_buf.sv
// One-entry holding register for a word accepted while the shifter is busy.
module ser_pend_buf
  import bit_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              pop,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CNT_W-1:0]  load_len,
  output logic [WORD_W-1:0] pend_word,
  output logic [CNT_W-1:0]  pend_len,
  output logic              pend_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_word <= '0;
      pend_len  <= '0;
      pend_vld  <= 1'b0;
    end else if (load) begin
      pend_word <= load_word;
      pend_len  <= load_len;
      pend_vld  <= 1'b1;
    end else if (pop) begin
      pend_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts words over valid/ready and emits them
// MSB-first, one bit per clock, with a one-word buffer for bubble-free streaming.
module bit_serializer
  import bit_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic              word_vld,
  output logic              word_rdy,
  output logic              in_bit,
  output logic              bit_vld,
  output logic              word_done,
  output logic              busy
);

  ser_state_e        state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic [WORD_W-1:0] pend_word;
  logic [CNT_W-1:0]  pend_len;
  logic              pend_vld;

  logic              xfer;
  logic              last;
  logic              use_pend;
  logic              do_load;
  logic              pend_load;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  load_len;
  logic [WORD_W-1:0] aligned;

  assign word_rdy = !pend_vld;
  assign xfer     = word_vld & word_rdy;
  assign busy     = (state == SHIFT) | pend_vld;

  // cnt counts bits still to emit after the one on in_bit; zero in SHIFT means
  // the final bit is showing, so the next word (pending first) loads this edge.
  always_comb begin
    last      = 1'b0;
    use_pend  = 1'b0;
    do_load   = 1'b0;
    pend_load = 1'b0;
    load_word = word_in;
    load_len  = eff_len(num_bits);
    aligned   = '0;

    last      = (state == SHIFT) && (cnt == '0);
    use_pend  = last && pend_vld;
    do_load   = ((state == IDLE) && xfer) || (last && (pend_vld || xfer));
    pend_load = xfer && (state == SHIFT) && !last;
    if (use_pend) begin
      load_word = pend_word;
      load_len  = pend_len;
    end
    aligned = load_word << (CNT_W'(WORD_W) - load_len);
  end

  ser_pend_buf u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pend_load),
    .pop       (use_pend),
    .load_word (word_in),
    .load_len  (eff_len(num_bits)),
    .pend_word (pend_word),
    .pend_len  (pend_len),
    .pend_vld  (pend_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      in_bit    <= 1'b0;
      bit_vld   <= 1'b0;
      word_done <= 1'b0;
    end else if (do_load) begin
      state     <= SHIFT;
      in_bit    <= aligned[WORD_W-1];
      shreg     <= aligned << 1;
      cnt       <= load_len - CNT_W'(1);
      bit_vld   <= 1'b1;
      word_done <= (load_len == CNT_W'(1));
    end else if ((state == SHIFT) && (cnt != '0)) begin
      in_bit    <= shreg[WORD_W-1];
      shreg     <= shreg << 1;
      cnt       <= cnt - CNT_W'(1);
      bit_vld   <= 1'b1;
      word_done <= (cnt == CNT_W'(1));
    end else begin
      state     <= IDLE;
      in_bit    <= 1'b0;
      bit_vld   <= 1'b0;
      word_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer against a word/bit-queue reference model.
module tb_bit_serializer;
  import bit_serial_pkg::*;

  typedef logic [1:0] bq_t[$];
  typedef struct {
    logic [WORD_W-1:0] w;
    logic [CNT_W-1:0]  nb;
  } wd_t;

  logic              clk;
  logic              rst_n;
  logic [WORD_W-1:0] word_in;
  logic [CNT_W-1:0]  num_bits;
  logic              word_vld;
  logic              word_rdy;
  logic              in_bit;
  logic              bit_vld;
  logic              word_done;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: bits of the word in flight, bits of the buffered word
  bq_t cur_q;
  bq_t pend_q;
  bit  pend_v;
  bit  m_bit, m_vld, m_done;

  wd_t txq[$];
  int  cyc, vld_cnt, done_cnt, first_vld, last_vld;

  bit_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_in   (word_in),
    .num_bits  (num_bits),
    .word_vld  (word_vld),
    .word_rdy  (word_rdy),
    .in_bit    (in_bit),
    .bit_vld   (bit_vld),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A word becomes a list of {bit, is_last} pairs, MSB of its effective length first.
  function automatic bq_t expand(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] nb);
    bq_t q;
    int  len;
    len = (nb == 0 || int'(nb) > int'(WORD_W)) ? int'(WORD_W) : int'(nb);
    for (int k = 0; k < len; k++) q.push_back({w[len-1-k], (k == len - 1)});
    return q;
  endfunction

  function automatic void model_reset();
    cur_q.delete();
    pend_q.delete();
    pend_v = 1'b0;
    m_bit  = 1'b0;
    m_vld  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_edge(input bit vld, input logic [WORD_W-1:0] w,
                                     input logic [CNT_W-1:0] nb);
    bit         xfer;
    bit         used;
    logic [1:0] e;
    xfer = vld && !pend_v;
    used = 1'b0;
    if (cur_q.size() == 0) begin
      if (pend_v) begin
        cur_q  = pend_q;
        pend_v = 1'b0;
      end else if (xfer) begin
        cur_q = expand(w, nb);
        used  = 1'b1;
      end
    end
    if (xfer && !used) begin
      pend_q = expand(w, nb);
      pend_v = 1'b1;
    end
    if (cur_q.size() > 0) begin
      e      = cur_q.pop_front();
      m_bit  = e[1];
      m_done = e[0];
      m_vld  = 1'b1;
    end else begin
      m_bit  = 1'b0;
      m_done = 1'b0;
      m_vld  = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    check("in_bit",    32'(in_bit),    32'(m_bit));
    check("bit_vld",   32'(bit_vld),   32'(m_vld));
    check("word_done", 32'(word_done), 32'(m_done));
    check("busy",      32'(busy),      32'(m_vld | pend_v));
    check("word_rdy",  32'(word_rdy),  32'(!pend_v));
  endtask

  task automatic cycle(input bit vld, input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] nb);
    word_vld = vld;
    word_in  = w;
    num_bits = nb;
    @(posedge clk);
    model_edge(vld, w, nb);
    #1;
    check_outputs();
    cyc++;
    if (bit_vld) begin
      vld_cnt++;
      last_vld = cyc;
      if (first_vld < 0) first_vld = cyc;
    end
    if (word_done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, WORD_W'($urandom), CNT_W'($urandom));
  endtask

  task automatic clear_stats();
    vld_cnt   = 0;
    done_cnt  = 0;
    first_vld = -1;
    last_vld  = -1;
  endtask

  // Offer queued words in order; a word retires when the model says it was accepted.
  task automatic run_stream(input int drop_pct, input int max_cycles);
    bit take;
    for (int c = 0; c < max_cycles && txq.size() > 0; c++) begin
      if ($urandom_range(99) >= drop_pct) begin
        take = !pend_v;
        cycle(1'b1, txq[0].w, txq[0].nb);
        if (take) void'(txq.pop_front());
      end else begin
        cycle(1'b0, WORD_W'($urandom), CNT_W'($urandom));
      end
    end
    check("stream_drain", 32'(txq.size()), 32'd0);
    txq.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    word_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [WORD_W-1:0] got_word;

  initial begin
    cyc = 0;
    clear_stats();
    model_reset();
    rst_n    = 1'b0;
    word_vld = 1'b1;
    word_in  = 8'hFF;
    num_bits = '0;
    #3;
    check("rst_in_bit",    32'(in_bit),    32'd0);
    check("rst_bit_vld",   32'(bit_vld),   32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_word_rdy",  32'(word_rdy),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ignored_vld", 32'(bit_vld), 32'd0);
    @(negedge clk);
    word_vld = 1'b0;
    rst_n    = 1'b1;
    idle(2);

    // full-width word via num_bits=0
    clear_stats();
    got_word = '0;
    cycle(1'b1, 8'hA0, 4'd0);
    got_word = {got_word[WORD_W-2:0], in_bit};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, '0, '0);
      got_word = {got_word[WORD_W-2:0], in_bit};
    end
    check("t1_bits", 32'(got_word), 32'h0000_00A0);
    check("t1_done_last", 32'(word_done), 32'd1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    idle(2);

    // short word
    clear_stats();
    cycle(1'b1, 8'h0F, 4'd4);
    idle(6);
    check("t2_vld_cnt", 32'(vld_cnt), 32'd4);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // back-to-back stream with valid held
    clear_stats();
    txq.push_back('{8'h55, 4'd8});
    txq.push_back('{8'h03, 4'd2});
    txq.push_back('{8'h81, 4'd8});
    run_stream(0, 40);
    idle(20);
    check("t3_vld_cnt", 32'(vld_cnt), 32'd18);
    check("t3_contig", 32'(last_vld - first_vld + 1), 32'd18);
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // 1-bit words every cycle
    clear_stats();
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'h01, 4'd1);
    check("t4_vld_cnt", 32'(vld_cnt), 32'd12);
    check("t4_done_cnt", 32'(done_cnt), 32'd12);
    idle(2);

    // asynchronous reset mid-word with a pending word
    cycle(1'b1, 8'hFF, 4'd8);
    cycle(1'b1, 8'h3C, 4'd5);
    cycle(1'b0, '0, '0);
    check("t5_pend_before", 32'(word_rdy), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_in_bit",   32'(in_bit),   32'd0);
    check("t5_bit_vld",  32'(bit_vld),  32'd0);
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_word_rdy", 32'(word_rdy), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    idle(6);
    check("t5_no_emit", 32'(vld_cnt), 32'd0);

    // out-of-range length clamps to full width
    clear_stats();
    got_word = '0;
    cycle(1'b1, 8'h80, 4'd9);
    got_word = {got_word[WORD_W-2:0], in_bit};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, '0, '0);
      got_word = {got_word[WORD_W-2:0], in_bit};
    end
    check("t6_bits", 32'(got_word), 32'h0000_0080);
    check("t6_done_last", 32'(word_done), 32'd1);
    idle(2);
    check("t6_vld_cnt", 32'(vld_cnt), 32'd8);

    // randomized streams with random gaps and occasional reset
    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = int'($urandom_range(6, 1));
      for (int i = 0; i < nw; i++) txq.push_back('{WORD_W'($urandom), CNT_W'($urandom_range(15))});
      run_stream(int'($urandom_range(60)), 200);
      if ($urandom_range(9) == 0) do_reset();
      idle(int'($urandom_range(12)));
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
